// File: rtl/adder_pipe_gl_pkg.sv
// Shared defaults and helpers for the carry-select pipelined adder.
package adder_pipe_gl_pkg;

    localparam int unsigned DEF_NBITS    = 32;
    localparam int unsigned DEF_SEG_BITS = 8;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic ovf_calc(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_pipe_defs.v
// Stage-count derivation and configuration legality shared by ALU blocks.
`ifndef ADDER_PIPE_DEFS_V
`define ADDER_PIPE_DEFS_V

`define ADDER_PIPE_NSEG(nbits, segbits) ((nbits) / (segbits))

`define ADDER_PIPE_CFG_OK(nbits, segbits) \
    (((segbits) > 0) && ((nbits) > 0) && (((nbits) % (segbits)) == 0))

`endif

// File: rtl/adder_seg_csel_gl.sv
// Stateless carry-select segment: both carry-in sums, muxed by the real carry.
module adder_seg_csel_gl
    import adder_pipe_gl_pkg::*;
#(
    parameter int unsigned p_w = DEF_SEG_BITS
) (
    input  logic [p_w-1:0] i_a,
    input  logic [p_w-1:0] i_b,
    input  logic           i_cin,
    output logic [p_w-1:0] o_sum_c,
    output logic           o_cout_c
);

    localparam int unsigned W1 = p_w + 1;

    logic [p_w:0] w_s0;
    logic [p_w:0] w_s1;

    // Precompute carry-0 and carry-1 results, then select.
    assign w_s0                = {1'b0, i_a} + {1'b0, i_b};
    assign w_s1                = w_s0 + W1'(1);
    assign {o_cout_c, o_sum_c} = i_cin ? w_s1 : w_s0;

endmodule

// File: rtl/adder_pipe_gl.sv
// Pipelined carry-select add/sub: one segment resolved per stage, valid/ready flow.
`include "adder_pipe_defs.v"

module adder_pipe_gl
    import adder_pipe_gl_pkg::*;
#(
    parameter int unsigned p_nbits    = DEF_NBITS,
    parameter int unsigned p_seg_bits = DEF_SEG_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               cin,
    input  logic               sub,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic               zero
);

    localparam int unsigned NSEG = `ADDER_PIPE_NSEG(p_nbits, p_seg_bits);
    localparam int unsigned LAST = NSEG - 1;
    localparam int unsigned MSB  = p_nbits - 1;

    if (!(`ADDER_PIPE_CFG_OK(p_nbits, p_seg_bits))) begin : g_bad_cfg
        $error("adder_pipe_gl: p_nbits must be a positive multiple of p_seg_bits");
    end

    // Per-stage registers: operands travel with the partially resolved sum.
    logic [NSEG-1:0]       r_val;
    logic [NSEG-1:0]       r_c;
    logic [p_nbits-1:0]    r_a [NSEG];
    logic [p_nbits-1:0]    r_b [NSEG];
    logic [p_nbits-1:0]    r_s [NSEG];
    logic                  r_zero;

    logic [p_nbits-1:0]    w_beff;
    logic                  w_ceff;
    logic [NSEG-1:0]       w_adv;
    logic [NSEG-1:0]       w_v_src;
    logic [NSEG-1:0]       w_c_src;
    logic [NSEG-1:0]       w_seg_co;
    logic [p_nbits-1:0]    w_a_src [NSEG];
    logic [p_nbits-1:0]    w_b_src [NSEG];
    logic [p_nbits-1:0]    w_s_src [NSEG];
    logic [p_nbits-1:0]    w_s_nx  [NSEG];
    logic [p_seg_bits-1:0] w_seg_sum [NSEG];

    assign w_beff = sub ? ~in1 : in1;
    assign w_ceff = cin ^ sub;

    // Advance chain: a stage moves if it is empty or everything downstream moves.
    always_comb begin
        logic v_go;
        v_go  = out_rdy;
        w_adv = '0;
        for (int k = int'(LAST); k >= 0; k--) begin
            v_go     = v_go | ~r_val[k];
            w_adv[k] = v_go;
        end
    end

    // Stage inputs: stage 0 takes the port operands, stage k takes stage k-1.
    always_comb begin
        w_v_src    = '0;
        w_c_src    = '0;
        w_v_src[0] = in_val;
        w_c_src[0] = w_ceff;
        w_a_src[0] = in0;
        w_b_src[0] = w_beff;
        w_s_src[0] = '0;
        for (int k = 1; k < int'(NSEG); k++) begin
            w_v_src[k] = r_val[k-1];
            w_c_src[k] = r_c[k-1];
            w_a_src[k] = r_a[k-1];
            w_b_src[k] = r_b[k-1];
            w_s_src[k] = r_s[k-1];
        end
    end

    // One carry-select segment per stage.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        adder_seg_csel_gl #(
            .p_w      (p_seg_bits)
        ) u_seg (
            .i_a      (w_a_src[k][k*p_seg_bits +: p_seg_bits]),
            .i_b      (w_b_src[k][k*p_seg_bits +: p_seg_bits]),
            .i_cin    (w_c_src[k]),
            .o_sum_c  (w_seg_sum[k]),
            .o_cout_c (w_seg_co[k])
        );
    end

    // Splice each stage's freshly resolved segment into the running sum.
    always_comb begin
        for (int k = 0; k < int'(NSEG); k++) begin
            w_s_nx[k] = w_s_src[k];
            w_s_nx[k][k*p_seg_bits +: p_seg_bits] = w_seg_sum[k];
        end
    end

    // Pipeline registers; async clear drops every in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= '0;
            r_c    <= '0;
            r_zero <= 1'b0;
            for (int k = 0; k < int'(NSEG); k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NSEG); k++) begin
                if (w_adv[k]) begin
                    r_val[k] <= w_v_src[k];
                    r_c[k]   <= w_seg_co[k];
                    r_a[k]   <= w_a_src[k];
                    r_b[k]   <= w_b_src[k];
                    r_s[k]   <= w_s_nx[k];
                end
            end
            if (w_adv[LAST]) begin
                r_zero <= (w_s_nx[LAST] == '0);
            end
        end
    end

    assign in_rdy  = w_adv[0];
    assign out_val = r_val[LAST];
    assign sum     = r_s[LAST];
    assign cout    = r_c[LAST];
    assign zero    = r_zero;
    assign ovf     = ovf_calc(r_a[LAST][MSB], r_b[LAST][MSB], r_s[LAST][MSB]);

endmodule

// File: tb/tb_adder_pipe_gl.sv
// Directed bench for adder_pipe_gl: default 32/8 build plus a single-stage 16/16 build.
module tb_adder_pipe_gl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_val, in_rdy, cin, sub, out_val, out_rdy, cout, ovf, zero;
    logic [31:0] in0, in1, sum;

    logic        in_val16, in_rdy16, cin16, sub16, out_val16, out_rdy16, cout16, ovf16, zero16;
    logic [15:0] in0_16, in1_16, sum16;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_pipe_gl dut (
        .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy),
        .in0(in0), .in1(in1), .cin(cin), .sub(sub),
        .out_val(out_val), .out_rdy(out_rdy), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero)
    );

    adder_pipe_gl #(.p_nbits(16), .p_seg_bits(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_val(in_val16), .in_rdy(in_rdy16),
        .in0(in0_16), .in1(in1_16), .cin(cin16), .sub(sub16),
        .out_val(out_val16), .out_rdy(out_rdy16), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s);
        in_val = v;
        in0    = a;
        in1    = b;
        cin    = c;
        sub    = s;
    endtask

    // Single transaction with out_rdy high: latency and all result flags.
    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic [31:0] e_sum,
                        input logic e_co, input logic e_ovf, input logic e_zero);
        int lat;
        drive(1'b1, a, b, c, s);
        #1;
        check({tag, "_in_rdy"}, 64'(in_rdy), 64'(1));
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        lat = 1;
        while (out_val !== 1'b1 && lat < 16) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(4));
        check({tag, "_sum"},  64'(sum),  64'(e_sum));
        check({tag, "_cout"}, 64'(cout), 64'(e_co));
        check({tag, "_ovf"},  64'(ovf),  64'(e_ovf));
        check({tag, "_zero"}, 64'(zero), 64'(e_zero));
        tick();
        check({tag, "_drained"}, 64'(out_val), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int emit;
        int ghosts;
        logic [31:0] held;
        logic        hv;

        rst_n     = 1'b0;
        out_rdy   = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        in_val16  = 1'b0;
        in0_16    = 16'h0;
        in1_16    = 16'h0;
        cin16     = 1'b0;
        sub16     = 1'b0;
        out_rdy16 = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_out_val", 64'(out_val), 64'(0));
        check("rst_sum",     64'(sum),     64'(0));
        check("rst_cout",    64'(cout),    64'(0));
        check("rst_ovf",     64'(ovf),     64'(0));
        check("rst_zero",    64'(zero),    64'(0));
        rst_n = 1'b1;
        #1;
        check("idle_in_rdy", 64'(in_rdy), 64'(1));

        // Directed single transactions
        run1("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run1("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run1("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run1("sub_equal", 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run1("seg_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0, 1'b0);
        run1("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run1("sub_cin",   32'h0000_0009, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b0);

        // Back-to-back 1+1 .. 10+10
        for (int c = 0; c < 16; c++) begin
            if (c < 10) drive(1'b1, 32'(c + 1), 32'(c + 1), 1'b0, 1'b0);
            else        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            tick();
            check($sformatf("b2b_val_%0d", c), 64'(out_val), 64'((c >= 3) && (c <= 12)));
            if ((c >= 3) && (c <= 12))
                check($sformatf("b2b_sum_%0d", c), 64'(sum), 64'(2 * (c - 2)));
        end

        // Output stall: out_rdy low for 5 cycles, 6 inputs offered
        acc  = 0;
        emit = 0;
        for (int c = 1; c <= 20; c++) begin
            out_rdy = (c > 5);
            if (acc < 6) drive(1'b1, 32'(3 * (acc + 1)), 32'(acc + 1), 1'b0, 1'b0);
            else         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            #1;
            if (c == 4) check("stall_bubble_rdy", 64'(in_rdy), 64'(1));
            if (c == 5) begin
                check("stall_full_rdy", 64'(in_rdy), 64'(0));
                check("stall_accepted", 64'(acc), 64'(4));
            end
            if (c == 6) check("stall_full_pass", 64'({in_rdy, out_val}), 64'(2'b11));
            if (out_val && out_rdy) begin
                emit++;
                check($sformatf("stall_sum_%0d", emit), 64'(sum), 64'(4 * emit));
            end
            if (in_val && in_rdy) acc++;
            held = sum;
            hv   = out_val && !out_rdy;
            tick();
            if (hv) check($sformatf("stall_hold_%0d", c), 64'(sum), 64'(held));
        end
        check("stall_emit_count", 64'(emit), 64'(6));
        check("stall_acc_count",  64'(acc),  64'(6));
        out_rdy = 1'b1;

        // Mid-cycle reset with three transactions in flight
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'h1111_0000 + 32'(c), 32'h0000_1000, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("rst_mid_pre_val", 64'(out_val), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_val", 64'(out_val), 64'(0));
        check("rst_mid_sum",     64'(sum),     64'(0));
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        ghosts = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_val) ghosts++;
        end
        check("rst_mid_no_ghost", 64'(ghosts), 64'(0));
        run1("post_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

        // Single-stage 16/16 build
        in_val16 = 1'b1;
        in0_16   = 16'h8000;
        in1_16   = 16'h8000;
        #1;
        check("n1_in_rdy", 64'(in_rdy16), 64'(1));
        tick();
        in_val16 = 1'b0;
        check("n1_out_val", 64'(out_val16), 64'(1));
        check("n1_sum",     64'(sum16),     64'(0));
        check("n1_cout",    64'(cout16),    64'(1));
        check("n1_ovf",     64'(ovf16),     64'(1));
        check("n1_zero",    64'(zero16),    64'(1));
        tick();
        check("n1_drained", 64'(out_val16), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_pipe_gl.md
ADDER_PIPE_GL -- requirements
Module: adder_pipe_gl

Interface
REQ-001 SHALL have parameter p_nbits, default 32: operand and sum width; a positive multiple of p_seg_bits.
REQ-002 SHALL have parameter p_seg_bits, default 8: carry-select segment width; one segment per pipeline stage, so NSEG = p_nbits/p_seg_bits stages.
REQ-003 SHALL have port clk, input, 1: rising-edge clock; the block's only clock.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_val, input, 1: operand transaction valid.
REQ-006 SHALL have port in_rdy, output, 1: block accepts a transaction this cycle.
REQ-007 SHALL have port in0, input, p_nbits: operand A.
REQ-008 SHALL have port in1, input, p_nbits: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in.
REQ-010 SHALL have port sub, input, 1: 1 selects A - B - cin, 0 selects A + B + cin.
REQ-011 SHALL have port out_val, output, 1: result valid.
REQ-012 SHALL have port out_rdy, input, 1: consumer accepts the result.
REQ-013 SHALL have port sum, output, p_nbits: result, modulo 2^p_nbits.
REQ-014 SHALL have port cout, output, 1: carry out of the MSB; for sub, 1 means no borrow.
REQ-015 SHALL have port ovf, output, 1: two's-complement signed overflow.
REQ-016 SHALL have port zero, output, 1: sum equals 0.

Function
REQ-017 SHALL transfer an input when in_val && in_rdy are both 1 at a rising clk edge, and an output when out_val && out_rdy are both 1.
REQ-018 SHALL compute Beff = sub ? ~in1 : in1 and Ceff = cin ^ sub at input capture.
REQ-019 SHALL resolve segment k in stage k: compute both carry-0 and carry-1 sums of the segment, then select one with the registered carry from stage k-1 (Ceff for stage 0).
REQ-020 SHALL carry resolved low bits and unresolved high operand bits forward in per-stage registers.
REQ-021 SHALL give a latency of exactly NSEG cycles from input transfer to out_val when no stall occurs; default 4 cycles.
REQ-022 SHALL sustain one transaction per cycle with out_rdy held 1.
REQ-023 SHALL let stage k advance when its valid is 0 or stage k+1 advances; the output stage advances when out_rdy is 1 or out_val is 0.
REQ-024 SHALL set in_rdy equal to stage 0 advance; in_rdy may depend combinationally on out_rdy.
REQ-025 SHALL collapse bubbles: an empty stage accepts new data even while downstream stages stall.
REQ-026 SHALL hold sum, cout, ovf and zero stable while out_val && !out_rdy.
REQ-027 SHALL compute ovf = (A[msb] == Beff[msb]) && (sum[msb] != A[msb]).
REQ-028 SHALL deliver results strictly in input order, with no loss or duplication under any in_val/out_rdy pattern.
REQ-029 SHALL treat NSEG = 1 as a single-register adder with latency 1.
REQ-030 SHALL accept a new input and emit a result on the same edge when the pipeline is full and out_rdy is 1.

Reset
REQ-031 SHALL clear every stage valid bit immediately on rst_n low, regardless of clk.
REQ-032 SHALL hold out_val = 0 and sum, cout, ovf, zero at 0 during reset.
REQ-033 SHALL discard in-flight transactions when reset is asserted mid-operation.
REQ-034 SHALL hold in_rdy = 1 while rst_n is high and the pipeline is empty.
REQ-035 SHALL release from reset synchronously: the first capture is allowed at the first rising clk edge after rst_n rises.

Structure
REQ-036 SHALL place NSEG derivation and the p_nbits % p_seg_bits == 0 legality check in a shared include, adder_pipe_defs.v, reused by future ALU blocks.
REQ-037 SHALL use one sub-module, adder_seg_csel_gl: p_seg_bits-wide dual-sum segment with a carry mux, instantiated NSEG times by generate.
REQ-038 SHALL hold no state in adder_seg_csel_gl; all registers belong to adder_pipe_gl.

Verification
REQ-039 SHALL check: in0=0xFFFFFFFF, in1=0x00000001, cin=0, sub=0 -> after 4 cycles sum=0x00000000, cout=1, zero=1, ovf=0.
REQ-040 SHALL check: in0=0x7FFFFFFF, in1=0x00000001, add -> sum=0x80000000, ovf=1, cout=0; then in0=5, in1=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-041 SHALL check: back-to-back inputs 1+1, 2+2, ... 10+10 with out_rdy=1 -> out_val on 10 consecutive cycles with sums 2..20 in order.
REQ-042 SHALL check: 6 inputs, out_rdy=0 for 5 cycles then 1 -> in_rdy drops after 4 accepted, outputs held stable, all 6 results emerge in order.
REQ-043 SHALL check: rst_n pulsed low mid-clock with 3 transactions in flight -> out_val=0 at once, and none of the 3 results ever appears.
REQ-044 SHALL check: p_nbits=16, p_seg_bits=16 build, 0x8000+0x8000 -> 1-cycle latency, sum=0, cout=1, ovf=1, zero=1.
